// File: rtl/z80_bus_cycle_gen.sv
// Z80 bus initiator: turns valid/ready requests into timed memory, I/O and M1 cycles.
// Every bus-facing output is registered from the next-state decode.
module z80_bus_cycle_gen #(
  parameter int T_CLKS       = 1,
  parameter int IO_AUTO_WAIT = 1,
  parameter int WAIT_MAX     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic        req_m1,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        dout_oe,
  input  logic [7:0]  din,
  input  logic        wait_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        m1_n
);
  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

  localparam int TCW = (T_CLKS > 1) ? $clog2(T_CLKS) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(T_CLKS - 1);
  localparam logic [7:0] AUTO_W = 8'(IO_AUTO_WAIT);
  localparam logic [7:0] WMAX   = 8'(WAIT_MAX);

  state_t         state_reg, state_next;
  logic [TCW-1:0] tc_reg, tc_next;
  logic [7:0]     wcnt_reg, wcnt_next;
  logic           write_reg, write_next, io_reg, io_next, m1_reg, m1_next;
  logic           abort_reg, abort_next;
  logic [15:0]    addr_next;
  logic [7:0]     dout_next, rdata_next;
  logic           end_st, to_t3, in_t2w, in_t2w3, act;
  logic           rv_next, mreq_n_next, iorq_n_next, rd_n_next, wr_n_next, m1_n_next, oe_next;

  assign req_ready = (state_reg == IDLE) & ~rst;
  assign end_st    = (tc_reg == TC_LAST);

  always_comb begin
    state_next = state_reg;
    tc_next    = tc_reg;
    wcnt_next  = wcnt_reg;
    write_next = write_reg;
    io_next    = io_reg;
    m1_next    = m1_reg;
    abort_next = abort_reg;
    addr_next  = addr;
    dout_next  = dout;
    rdata_next = rsp_rdata;
    to_t3      = 1'b0;
    if (state_reg != IDLE)
      tc_next = end_st ? '0 : tc_reg + 1'b1;
    case (state_reg)
      IDLE: if (req_valid) begin
        state_next = T1;
        tc_next    = '0;
        wcnt_next  = '0;
        abort_next = 1'b0;
        write_next = req_write;
        io_next    = req_io;
        m1_next    = req_m1 & ~req_write & ~req_io;
        addr_next  = req_addr;
        dout_next  = req_wdata;
      end
      T1: if (end_st) state_next = T2;
      T2, TW: if (end_st) begin
        // Mandatory I/O waits come first; wait_n is only looked at afterwards.
        if (io_reg && (wcnt_reg < AUTO_W)) begin
          state_next = TW;
          wcnt_next  = wcnt_reg + 8'd1;
        end else if (wait_n) begin
          state_next = T3;
          to_t3      = 1'b1;
        end else if ((WAIT_MAX != 0) && (wcnt_reg >= WMAX)) begin
          state_next = T3;
          to_t3      = 1'b1;
          abort_next = 1'b1;
        end else begin
          state_next = TW;
          wcnt_next  = (wcnt_reg == 8'hFF) ? wcnt_reg : wcnt_reg + 8'd1;
        end
      end
      T3: if (end_st) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (to_t3 && !write_reg)
      rdata_next = abort_next ? 8'hFF : din;
  end

  always_comb begin
    act         = (state_next != IDLE);
    in_t2w      = (state_next == T2) || (state_next == TW);
    in_t2w3     = in_t2w || (state_next == T3);
    rv_next     = (state_next == T3) && (tc_next == TC_LAST);
    mreq_n_next = ~(act && !io_next);
    iorq_n_next = ~(io_next && in_t2w3);
    rd_n_next   = ~(!write_next && (io_next ? in_t2w3 : act));
    wr_n_next   = ~(write_next && in_t2w);
    m1_n_next   = ~(m1_next && (in_t2w || (state_next == T1)));
    oe_next     = write_next && act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tc_reg    <= '0;
      wcnt_reg  <= '0;
      write_reg <= 1'b0;
      io_reg    <= 1'b0;
      m1_reg    <= 1'b0;
      abort_reg <= 1'b0;
      addr      <= '0;
      dout      <= '0;
      rsp_rdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      dout_oe   <= 1'b0;
      mreq_n    <= 1'b1;
      iorq_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      m1_n      <= 1'b1;
    end else begin
      state_reg <= state_next;
      tc_reg    <= tc_next;
      wcnt_reg  <= wcnt_next;
      write_reg <= write_next;
      io_reg    <= io_next;
      m1_reg    <= m1_next;
      abort_reg <= abort_next;
      addr      <= addr_next;
      dout      <= dout_next;
      rsp_rdata <= rdata_next;
      rsp_valid <= rv_next;
      if (rv_next) rsp_err <= abort_next;
      dout_oe   <= oe_next;
      mreq_n    <= mreq_n_next;
      iorq_n    <= iorq_n_next;
      rd_n      <= rd_n_next;
      wr_n      <= wr_n_next;
      m1_n      <= m1_n_next;
    end
  end
endmodule

// File: tb/tb_z80_bus_cycle_gen.sv
// Directed bench: dut_a (T_CLKS=1, one I/O auto-wait, WAIT_MAX=4), dut_b (T_CLKS=2).
module tb_z80_bus_cycle_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_write = 1'b0, req_io = 1'b0, req_m1 = 1'b0, wait_n = 1'b1;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0, din = '0;

  logic        a_ready, a_rv, a_err, a_oe, a_rd_n, a_wr_n, a_mreq_n, a_iorq_n, a_m1_n;
  logic        b_ready, b_rv, b_err, b_oe, b_rd_n, b_wr_n, b_mreq_n, b_iorq_n, b_m1_n;
  logic [7:0]  a_rdata, a_dout, b_rdata, b_dout;
  logic [15:0] a_addr, b_addr;

  z80_bus_cycle_gen #(.T_CLKS(1), .IO_AUTO_WAIT(1), .WAIT_MAX(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(a_ready), .req_write(req_write),
    .req_io(req_io), .req_m1(req_m1), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err), .addr(a_addr), .dout(a_dout),
    .dout_oe(a_oe), .din(din), .wait_n(wait_n), .rd_n(a_rd_n), .wr_n(a_wr_n),
    .mreq_n(a_mreq_n), .iorq_n(a_iorq_n), .m1_n(a_m1_n));

  z80_bus_cycle_gen #(.T_CLKS(2), .IO_AUTO_WAIT(1), .WAIT_MAX(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(b_ready), .req_write(req_write),
    .req_io(req_io), .req_m1(req_m1), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err), .addr(b_addr), .dout(b_dout),
    .dout_oe(b_oe), .din(din), .wait_n(wait_n), .rd_n(b_rd_n), .wr_n(b_wr_n),
    .mreq_n(b_mreq_n), .iorq_n(b_iorq_n), .m1_n(b_m1_n));

  int sel_dut = 0;
  logic        o_ready, o_rv, o_err, o_oe, o_rd_n, o_wr_n, o_mreq_n, o_iorq_n, o_m1_n;
  logic [7:0]  o_rdata, o_dout;
  logic [15:0] o_addr;
  always_comb begin
    if (sel_dut == 0) begin
      o_ready = a_ready; o_rv = a_rv; o_err = a_err; o_oe = a_oe; o_rd_n = a_rd_n;
      o_wr_n = a_wr_n; o_mreq_n = a_mreq_n; o_iorq_n = a_iorq_n; o_m1_n = a_m1_n;
      o_rdata = a_rdata; o_dout = a_dout; o_addr = a_addr;
    end else begin
      o_ready = b_ready; o_rv = b_rv; o_err = b_err; o_oe = b_oe; o_rd_n = b_rd_n;
      o_wr_n = b_wr_n; o_mreq_n = b_mreq_n; o_iorq_n = b_iorq_n; o_m1_n = b_m1_n;
      o_rdata = b_rdata; o_dout = b_dout; o_addr = b_addr;
    end
  end

  int vectors = 0, miscompares = 0;
  // Bit k of each trace = signal active during the k-th clk after the accept clk.
  logic [15:0] v_mreq, v_iorq, v_rd, v_wr, v_m1, v_oe, v_rv, v_rdy;
  logic [7:0]  rv_rdata, dout2;
  logic        rv_err, rdy_at_req;
  logic [15:0] addr1;

  task automatic capture(input int sel, input logic w, input logic io, input logic m1,
                         input logic [15:0] a, input logic [7:0] wd, input logic [15:0] wpat,
                         input int n);
    @(negedge clk);
    sel_dut = sel; req_write = w; req_io = io; req_m1 = m1; req_addr = a; req_wdata = wd;
    wait_n = 1'b1;
    if (sel == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
    #1 rdy_at_req = o_ready;
    v_mreq = '0; v_iorq = '0; v_rd = '0; v_wr = '0; v_m1 = '0; v_oe = '0; v_rv = '0; v_rdy = '0;
    rv_rdata = 8'hxx; rv_err = 1'bx; addr1 = 'x; dout2 = 'x;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      req_valid_a = 1'b0; req_valid_b = 1'b0;
      wait_n = ~wpat[k];
      #1;
      v_mreq[k] = ~o_mreq_n; v_iorq[k] = ~o_iorq_n; v_rd[k] = ~o_rd_n; v_wr[k] = ~o_wr_n;
      v_m1[k] = ~o_m1_n; v_oe[k] = o_oe; v_rv[k] = o_rv; v_rdy[k] = o_ready;
      if (o_rv) begin rv_rdata = o_rdata; rv_err = o_err; end
      if (k == 1) addr1 = o_addr;
      if (k == 2) dout2 = o_dout;
    end
    wait_n = 1'b1;
    $display("txn dut=%0d w=%0d io=%0d m1=%0d addr=%h mreq=%h iorq=%h rd=%h wr=%h m1t=%h rv=%h rdata=%h err=%b",
             sel, w, io, m1, a, v_mreq, v_iorq, v_rd, v_wr, v_m1, v_rv, rv_rdata, rv_err);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); sel_dut = s; #1;
      vectors++;
      if ({o_mreq_n, o_iorq_n, o_rd_n, o_wr_n, o_m1_n} !== 5'b11111) begin
        miscompares++; $display("FAIL reset_strobes dut=%0d got %b want 11111", s,
                                {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n, o_m1_n}); end
      vectors++;
      if ({o_addr, o_dout, o_rdata, o_oe, o_rv, o_err, o_ready} !== 36'h0) begin
        miscompares++; $display("FAIL reset_regs dut=%0d got %h want 0", s,
                                {o_addr, o_dout, o_rdata, o_oe, o_rv, o_err, o_ready}); end
    end
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if ({a_ready, b_ready} !== 2'b11) begin
      miscompares++; $display("FAIL reset_ready got %b want 11", {a_ready, b_ready}); end
    $display("txn reset done");
  endtask

  task automatic test_mem_read;
    din = 8'h3C;
    capture(0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 16'h0000, 6);
    vectors++; if (rdy_at_req !== 1'b1) begin miscompares++; $display("FAIL mr_ready got %b want 1", rdy_at_req); end
    vectors++; if (v_mreq !== 16'h000E) begin miscompares++; $display("FAIL mr_mreq got %h want 000e", v_mreq); end
    vectors++; if (v_rd !== 16'h000E) begin miscompares++; $display("FAIL mr_rd got %h want 000e", v_rd); end
    vectors++; if ({v_wr, v_iorq, v_m1, v_oe} !== 64'h0) begin miscompares++; $display("FAIL mr_idle_strobes got %h want 0", {v_wr, v_iorq, v_m1, v_oe}); end
    vectors++; if (v_rv !== 16'h0008) begin miscompares++; $display("FAIL mr_rsp got %h want 0008", v_rv); end
    vectors++; if (v_rdy !== 16'h0070) begin miscompares++; $display("FAIL mr_ready_trace got %h want 0070", v_rdy); end
    vectors++; if ({rv_rdata, rv_err} !== {8'h3C, 1'b0}) begin miscompares++; $display("FAIL mr_data got %h/%b want 3c/0", rv_rdata, rv_err); end
    vectors++; if (addr1 !== 16'h0123) begin miscompares++; $display("FAIL mr_addr got %h want 0123", addr1); end
  endtask

  task automatic test_mem_write_wait;
    capture(0, 1'b1, 1'b0, 1'b0, 16'h6000, 8'hA5, 16'h000C, 8);
    vectors++; if (v_wr !== 16'h001C) begin miscompares++; $display("FAIL mw_wr got %h want 001c", v_wr); end
    vectors++; if (v_mreq !== 16'h003E) begin miscompares++; $display("FAIL mw_mreq got %h want 003e", v_mreq); end
    vectors++; if (v_oe !== 16'h003E) begin miscompares++; $display("FAIL mw_oe got %h want 003e", v_oe); end
    vectors++; if (v_rd !== 16'h0000) begin miscompares++; $display("FAIL mw_rd got %h want 0000", v_rd); end
    vectors++; if (v_rv !== 16'h0020) begin miscompares++; $display("FAIL mw_rsp got %h want 0020", v_rv); end
    vectors++; if (dout2 !== 8'hA5) begin miscompares++; $display("FAIL mw_dout got %h want a5", dout2); end
    vectors++; if ({rv_rdata, rv_err} !== {8'h3C, 1'b0}) begin miscompares++; $display("FAIL mw_rdata_hold got %h/%b want 3c/0", rv_rdata, rv_err); end
  endtask

  task automatic test_io_write;
    capture(0, 1'b1, 1'b1, 1'b1, 16'h7F00, 8'h11, 16'h0000, 6);
    vectors++; if (v_iorq !== 16'h001C) begin miscompares++; $display("FAIL io_iorq got %h want 001c", v_iorq); end
    vectors++; if (v_mreq !== 16'h0000) begin miscompares++; $display("FAIL io_mreq got %h want 0000", v_mreq); end
    vectors++; if (v_wr !== 16'h000C) begin miscompares++; $display("FAIL io_wr got %h want 000c", v_wr); end
    vectors++; if (v_oe !== 16'h001E) begin miscompares++; $display("FAIL io_oe got %h want 001e", v_oe); end
    vectors++; if (v_m1 !== 16'h0000) begin miscompares++; $display("FAIL io_m1 got %h want 0000", v_m1); end
    vectors++; if (v_rv !== 16'h0010) begin miscompares++; $display("FAIL io_rsp got %h want 0010", v_rv); end
  endtask

  task automatic test_m1_slow;
    din = 8'h5A;
    capture(1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 16'h0000, 8);
    vectors++; if (v_m1 !== 16'h001E) begin miscompares++; $display("FAIL m1_m1 got %h want 001e", v_m1); end
    vectors++; if (v_rd !== 16'h007E) begin miscompares++; $display("FAIL m1_rd got %h want 007e", v_rd); end
    vectors++; if (v_rv !== 16'h0040) begin miscompares++; $display("FAIL m1_rsp got %h want 0040", v_rv); end
    vectors++; if ({rv_rdata, rv_err} !== {8'h5A, 1'b0}) begin miscompares++; $display("FAIL m1_data got %h/%b want 5a/0", rv_rdata, rv_err); end
  endtask

  task automatic test_timeout;
    din = 8'h77;
    capture(0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 16'hFFFE, 9);
    vectors++; if (v_rd !== 16'h00FE) begin miscompares++; $display("FAIL to_rd got %h want 00fe", v_rd); end
    vectors++; if (v_mreq !== 16'h00FE) begin miscompares++; $display("FAIL to_mreq got %h want 00fe", v_mreq); end
    vectors++; if (v_rv !== 16'h0080) begin miscompares++; $display("FAIL to_rsp got %h want 0080", v_rv); end
    vectors++; if ({rv_rdata, rv_err} !== {8'hFF, 1'b1}) begin miscompares++; $display("FAIL to_data got %h/%b want ff/1", rv_rdata, rv_err); end
    vectors++; if (a_err !== 1'b1) begin miscompares++; $display("FAIL to_err_hold got %b want 1", a_err); end
  endtask

  task automatic test_back_to_back;
    din = 8'hC3;
    capture(0, 1'b0, 1'b0, 1'b0, 16'h0456, 8'h00, 16'h0000, 3);
    vectors++; if ({v_rv, rv_rdata, rv_err} !== {16'h0008, 8'hC3, 1'b0}) begin miscompares++;
      $display("FAIL b2b_first got %h/%h/%b want 0008/c3/0", v_rv, rv_rdata, rv_err); end
    din = 8'h96;
    capture(0, 1'b0, 1'b0, 1'b0, 16'h0457, 8'h00, 16'h0000, 4);
    vectors++; if (rdy_at_req !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b want 1", rdy_at_req); end
    vectors++; if ({v_mreq, v_rv, rv_rdata, addr1} !== {16'h000E, 16'h0008, 8'h96, 16'h0457}) begin miscompares++;
      $display("FAIL b2b_second got %h/%h/%h/%h want 000e/0008/96/0457", v_mreq, v_rv, rv_rdata, addr1); end
  endtask

  task automatic test_reset_mid_cycle;
    logic saw_rv;
    @(negedge clk);
    sel_dut = 0; req_write = 1'b1; req_io = 1'b0; req_m1 = 1'b0; req_addr = 16'h2222;
    req_wdata = 8'h5C; wait_n = 1'b1; req_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid_a = 1'b0; wait_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    vectors++; if ({a_wr_n, a_oe} !== 2'b01) begin miscompares++; $display("FAIL rst_in_tw got %b want 01", {a_wr_n, a_oe}); end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({a_mreq_n, a_iorq_n, a_rd_n, a_wr_n, a_m1_n, a_oe, a_rv, a_ready} !== 8'b11111000) begin miscompares++;
      $display("FAIL rst_release got %b want 11111000", {a_mreq_n, a_iorq_n, a_rd_n, a_wr_n, a_m1_n, a_oe, a_rv, a_ready}); end
    @(negedge clk); rst = 1'b0; wait_n = 1'b1; #1;
    vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", a_ready); end
    saw_rv = 1'b0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); #1; saw_rv = saw_rv | a_rv; end
    vectors++; if (saw_rv !== 1'b0) begin miscompares++; $display("FAIL rst_no_rsp got %b want 0", saw_rv); end
    $display("txn reset mid-cycle write addr=2222");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write_wait();
    test_io_write();
    test_m1_slow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
